// File: rtl/mux2t1_64_arb_pkg.sv
// Shared types for the two-requester 64-bit round-robin arbiter.
// Holds the grant FSM state encoding, the default width and the idle pick rule.
package mux2t1_64_arb_pkg;

   localparam int WIDTH_DEFAULT = 64;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_e;

   // Idle arbitration: requester 1 wins when it is alone or holds priority.
   function automatic logic idle_pick1(
      input logic v0,
      input logic v1,
      input logic prio
   );
      return v1 & (~v0 | prio);
   endfunction

endpackage

// File: rtl/mux2t1_64_arb_if.sv
// Channel bundle: two producer valid/ready/last/data ports plus one consumer port.
// master = producers and consumer side, slave = arbiter side.
interface mux2t1_64_arb_if
   import mux2t1_64_arb_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
);

   logic             req0_valid;
   logic [WIDTH-1:0] req0_data;
   logic             req0_last;
   logic             req0_ready;

   logic             req1_valid;
   logic [WIDTH-1:0] req1_data;
   logic             req1_last;
   logic             req1_ready;

   logic             o_valid;
   logic [WIDTH-1:0] o_data;
   logic             o_src;
   logic             o_last;
   logic             o_ready;

   modport master (
      output req0_valid, req0_data, req0_last,
      input  req0_ready,
      output req1_valid, req1_data, req1_last,
      input  req1_ready,
      input  o_valid, o_data, o_src, o_last,
      output o_ready
   );

   modport slave (
      input  req0_valid, req0_data, req0_last,
      output req0_ready,
      input  req1_valid, req1_data, req1_last,
      output req1_ready,
      output o_valid, o_data, o_src, o_last,
      input  o_ready
   );

endinterface

// File: rtl/mux2t1_64_arb_rr_grant_fsm.sv
// rr_grant_fsm: round-robin grant with burst ownership for two requesters.
// In: clk, rst_n, req0/1 valid+last, can_load. Out: grant0, grant1.
module rr_grant_fsm
   import mux2t1_64_arb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req0_valid,
   input  logic req0_last,
   input  logic req1_valid,
   input  logic req1_last,
   input  logic can_load,
   output logic grant0,
   output logic grant1
);

   state_e state_q, state_d;
   logic   prio_q, prio_d;
   logic   acc0, acc1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
      end
   end

   // Last beat hands priority to the other side.
   always_comb begin
      acc0    = req0_valid & grant0 & can_load;
      acc1    = req1_valid & grant1 & can_load;
      state_d = state_q;
      prio_d  = prio_q;
      unique case (1'b1)
         acc0: begin
            state_d = req0_last ? IDLE : OWN0;
            if (req0_last) prio_d = 1'b1;
         end
         acc1: begin
            state_d = req1_last ? IDLE : OWN1;
            if (req1_last) prio_d = 1'b0;
         end
         default: ;
      endcase
   end

   // An owner keeps the grant even while its valid is low.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      unique case (state_q)
         OWN0: grant0 = 1'b1;
         OWN1: grant1 = 1'b1;
         default: begin
            grant1 = idle_pick1(req0_valid, req1_valid, prio_q);
            grant0 = req0_valid & ~grant1;
         end
      endcase
   end

endmodule

// File: rtl/mux2t1_64_arb.sv
// mux2t1_64_arb: shares one registered WIDTH-bit channel between two producers.
// Ports: clk, rst_n (async, low), bus (slave): req0/1 handshakes in, o_* out.
module mux2t1_64_arb
   import mux2t1_64_arb_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
)(
   input  logic               clk,
   input  logic               rst_n,
   mux2t1_64_arb_if.slave     bus
);

   logic             can_load;
   logic             grant0, grant1;
   logic             acc0, acc1;
   logic [WIDTH-1:0] sel_data;
   logic             sel_last;

   logic             o_valid_q, o_valid_d;
   logic [WIDTH-1:0] o_data_q, o_data_d;
   logic             o_src_q, o_src_d;
   logic             o_last_q, o_last_d;

   // Output slot is free or drains this cycle.
   assign can_load = ~o_valid_q | bus.o_ready;

   assign bus.req0_ready = can_load & grant0 & rst_n;
   assign bus.req1_ready = can_load & grant1 & rst_n;

   assign acc0 = bus.req0_valid & bus.req0_ready;
   assign acc1 = bus.req1_valid & bus.req1_ready;

   rr_grant_fsm u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (bus.req0_valid),
      .req0_last  (bus.req0_last),
      .req1_valid (bus.req1_valid),
      .req1_last  (bus.req1_last),
      .can_load   (can_load),
      .grant0     (grant0),
      .grant1     (grant1)
   );

   assign sel_data = grant1 ? bus.req1_data : bus.req0_data;
   assign sel_last = grant1 ? bus.req1_last : bus.req0_last;

   always_comb begin
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      o_src_d   = o_src_q;
      o_last_d  = o_last_q;
      if (acc0 | acc1) begin
         o_valid_d = 1'b1;
         o_data_d  = sel_data;
         o_src_d   = grant1;
         o_last_d  = sel_last;
      end else if (bus.o_ready) begin
         o_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         o_src_q   <= 1'b0;
         o_last_q  <= 1'b0;
      end else begin
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         o_src_q   <= o_src_d;
         o_last_q  <= o_last_d;
      end
   end

   assign bus.o_valid = o_valid_q;
   assign bus.o_data  = o_data_q;
   assign bus.o_src   = o_src_q;
   assign bus.o_last  = o_last_q;

endmodule

// File: tb/tb_mux2t1_64_arb.sv
// Bench for mux2t1_64_arb: directed scenarios plus randomized bursts.
// Expected values come from a cycle-level arbiter model kept in the bench.
module tb_mux2t1_64_arb;
   import mux2t1_64_arb_pkg::*;

   localparam int W = 64;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mux2t1_64_arb_if #(.WIDTH(W)) bus ();

   mux2t1_64_arb #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Model: owner (-1 none), round-robin pointer, output slot contents.
   int         m_own;
   bit         m_prio;
   bit         m_ov;
   bit         m_os;
   bit         m_ol;
   logic [W-1:0] m_od;

   function automatic void m_reset();
      m_own  = -1;
      m_prio = 1'b0;
      m_ov   = 1'b0;
      m_os   = 1'b0;
      m_ol   = 1'b0;
      m_od   = '0;
   endfunction

   // Would requester k be ready given the present inputs?
   function automatic bit m_rdy(int k);
      bit cl;
      int w;
      cl = !m_ov || bus.o_ready;
      if (m_own >= 0) w = m_own;
      else if (bus.req0_valid && bus.req1_valid) w = int'(m_prio);
      else if (bus.req0_valid) w = 0;
      else if (bus.req1_valid) w = 1;
      else w = -1;
      return rst_n && cl && (w == k);
   endfunction

   task automatic tick();
      bit a0, a1, l0, l1, ordy;
      logic [W-1:0] d0, d1;
      a0   = bus.req0_valid && m_rdy(0);
      a1   = bus.req1_valid && m_rdy(1);
      d0   = bus.req0_data;
      d1   = bus.req1_data;
      l0   = bus.req0_last;
      l1   = bus.req1_last;
      ordy = bus.o_ready;
      @(posedge clk);
      if (a0) begin
         m_od = d0; m_os = 1'b0; m_ol = l0; m_ov = 1'b1;
         m_own = l0 ? -1 : 0;
         if (l0) m_prio = 1'b1;
      end else if (a1) begin
         m_od = d1; m_os = 1'b1; m_ol = l1; m_ov = 1'b1;
         m_own = l1 ? -1 : 1;
         if (l1) m_prio = 1'b0;
      end else if (ordy) begin
         m_ov = 1'b0;
      end
      #1;
   endtask

   task automatic drive(
      input bit v0, input logic [W-1:0] d0, input bit l0,
      input bit v1, input logic [W-1:0] d1, input bit l1,
      input bit ordy
   );
      bus.req0_valid = v0; bus.req0_data = d0; bus.req0_last = l0;
      bus.req1_valid = v1; bus.req1_data = d1; bus.req1_last = l1;
      bus.o_ready    = ordy;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_reset();
      bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_last = 1'b0;
      bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_last = 1'b0;
      bus.o_ready = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      bus.req0_valid = 1'b1;
      bus.req0_data  = 64'hFFFF_0000_FFFF_0000;
      bus.o_ready    = 1'b1;
      #1;
      checks++;
      if (bus.o_valid !== 1'b0) begin
         errors++; $display("FAIL reset_o_valid got %0b exp 0", bus.o_valid);
      end
      checks++;
      if (bus.o_data !== 64'h0) begin
         errors++; $display("FAIL reset_o_data got %h exp 0", bus.o_data);
      end
      checks++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready got %0b%0b exp 00", bus.req0_ready, bus.req1_ready);
      end
      checks++;
      if (dut.u_fsm.state_q !== IDLE || dut.u_fsm.prio_q !== 1'b0) begin
         errors++;
         $display("FAIL reset_fsm got st=%0d prio=%0b exp 0/0",
                  dut.u_fsm.state_q, dut.u_fsm.prio_q);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 64'h1234_5678_9ABC_DEF0, 1, 0, '0, 0, 1);
      checks++;
      if (bus.req0_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
         errors++;
         $display("FAIL first_accept got rdy=%0b ov=%0b exp 1/0", bus.req0_ready, bus.o_valid);
      end
      tick();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== 64'h1234_5678_9ABC_DEF0
          || bus.o_src !== 1'b0 || bus.o_last !== 1'b1) begin
         errors++;
         $display("FAIL first_beat got v=%0b d=%h s=%0b l=%0b exp 1/123456789abcdef0/0/1",
                  bus.o_valid, bus.o_data, bus.o_src, bus.o_last);
      end
      drive(0, '0, 0, 0, '0, 0, 1);
      tick();
   endtask

   task automatic test_contention();
      logic prev;
      for (int i = 0; i < 6; i++) begin
         drive(1, 64'hAAAA_AAAA_AAAA_AAAA, 1, 1, 64'h5555_5555_5555_5555, 1, 1);
         checks++;
         if (bus.req0_ready !== m_rdy(0) || bus.req1_ready !== m_rdy(1)) begin
            errors++;
            $display("FAIL contention_ready got %0b%0b exp %0b%0b",
                     bus.req0_ready, bus.req1_ready, m_rdy(0), m_rdy(1));
         end
         tick();
         checks++;
         if (bus.o_valid !== 1'b1 || bus.o_data !== m_od || bus.o_src !== m_os) begin
            errors++;
            $display("FAIL contention_out got v=%0b d=%h s=%0b exp 1/%h/%0b",
                     bus.o_valid, bus.o_data, bus.o_src, m_od, m_os);
         end
         if (i > 0) begin
            checks++;
            if (bus.o_src !== ~prev) begin
               errors++;
               $display("FAIL contention_alt got src=%0b exp %0b", bus.o_src, ~prev);
            end
         end
         prev = bus.o_src;
      end
      drive(0, '0, 0, 0, '0, 0, 1);
      tick();
   endtask

   task automatic test_burst_hold();
      int  b;
      bit  v0, v1, e0;
      b = 1;
      for (int c = 0; c < 5; c++) begin
         v0 = (b <= 3);
         v1 = (c > 0);
         drive(v0, 64'(b), (b == 3), v1, 64'hB1B1, 1, 1);
         e0 = m_rdy(0);
         checks++;
         if (bus.req0_ready !== e0 || bus.req1_ready !== m_rdy(1)) begin
            errors++;
            $display("FAIL burst_ready got %0b%0b exp %0b%0b",
                     bus.req0_ready, bus.req1_ready, e0, m_rdy(1));
         end
         if (b >= 2 && b <= 3) begin
            checks++;
            if (bus.req1_ready !== 1'b0) begin
               errors++; $display("FAIL burst_hold_r1 got %0b exp 0", bus.req1_ready);
            end
         end
         if (c == 3) begin
            checks++;
            if (bus.req1_ready !== 1'b1) begin
               errors++; $display("FAIL burst_handover got %0b exp 1", bus.req1_ready);
            end
         end
         tick();
         if (v0 && e0) begin
            checks++;
            if (bus.o_src !== 1'b0 || bus.o_data !== 64'(b)) begin
               errors++;
               $display("FAIL burst_beat got s=%0b d=%h exp 0/%h", bus.o_src, bus.o_data, 64'(b));
            end
            b++;
         end
         checks++;
         if (bus.o_data !== m_od || bus.o_src !== m_os || bus.o_last !== m_ol) begin
            errors++;
            $display("FAIL burst_out got d=%h s=%0b exp %h/%0b", bus.o_data, bus.o_src, m_od, m_os);
         end
      end
      drive(0, '0, 0, 0, '0, 0, 1);
      tick();
   endtask

   task automatic test_backpressure();
      drive(1, 64'hC0FFEE, 1, 0, '0, 0, 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1, 64'hD00D, 1, 1, 64'hBEEF, 1, 0);
         checks++;
         if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready got %0b%0b exp 00", bus.req0_ready, bus.req1_ready);
         end
         tick();
         checks++;
         if (bus.o_valid !== 1'b1 || bus.o_data !== 64'hC0FFEE) begin
            errors++;
            $display("FAIL bp_stable got v=%0b d=%h exp 1/c0ffee", bus.o_valid, bus.o_data);
         end
      end
      drive(1, 64'hD00D, 1, 1, 64'hBEEF, 1, 1);
      checks++;
      if ((bus.req0_ready | bus.req1_ready) !== 1'b1 || bus.req0_ready !== m_rdy(0)) begin
         errors++;
         $display("FAIL bp_release got %0b%0b exp %0b%0b",
                  bus.req0_ready, bus.req1_ready, m_rdy(0), m_rdy(1));
      end
      tick();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== m_od || bus.o_src !== m_os) begin
         errors++;
         $display("FAIL bp_next got d=%h s=%0b exp %h/%0b", bus.o_data, bus.o_src, m_od, m_os);
      end
      drive(0, '0, 0, 0, '0, 0, 1);
      repeat (2) tick();
   endtask

   task automatic test_owner_gap();
      drive(0, '0, 0, 1, 64'h11, 0, 1);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1, 64'h22, 1, 0, '0, 0, 1);
         checks++;
         if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL gap_ready got %0b%0b exp 01", bus.req0_ready, bus.req1_ready);
         end
         tick();
         checks++;
         if (dut.u_fsm.state_q !== OWN1) begin
            errors++; $display("FAIL gap_state got %0d exp %0d", dut.u_fsm.state_q, OWN1);
         end
      end
      drive(1, 64'h22, 1, 1, 64'h12, 1, 1);
      checks++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
         errors++;
         $display("FAIL gap_last_ready got %0b%0b exp 01", bus.req0_ready, bus.req1_ready);
      end
      tick();
      checks++;
      if (bus.o_data !== 64'h12 || dut.u_fsm.state_q !== IDLE) begin
         errors++;
         $display("FAIL gap_last got d=%h st=%0d exp 12/0", bus.o_data, dut.u_fsm.state_q);
      end
      drive(1, 64'h22, 1, 0, '0, 0, 1);
      checks++;
      if (bus.req0_ready !== 1'b1) begin
         errors++; $display("FAIL gap_after got %0b exp 1", bus.req0_ready);
      end
      tick();
      drive(0, '0, 0, 0, '0, 0, 1);
      tick();
   endtask

   task automatic test_reset_mid_burst();
      drive(1, 64'h1, 0, 0, '0, 0, 1);
      tick();
      drive(1, 64'h2, 0, 0, '0, 0, 1);
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      checks++;
      if (dut.u_fsm.state_q !== IDLE || dut.u_fsm.prio_q !== 1'b0) begin
         errors++;
         $display("FAIL midrst_fsm got st=%0d prio=%0b exp 0/0",
                  dut.u_fsm.state_q, dut.u_fsm.prio_q);
      end
      checks++;
      if (bus.o_valid !== 1'b0 || bus.req0_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrst_out got v=%0b r0=%0b exp 0/0", bus.o_valid, bus.req0_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 64'hA0, 1, 1, 64'hA1, 1, 1);
      checks++;
      if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrst_win got %0b%0b exp 10", bus.req0_ready, bus.req1_ready);
      end
      tick();
      checks++;
      if (bus.o_src !== 1'b0 || bus.o_data !== 64'hA0) begin
         errors++;
         $display("FAIL midrst_beat got s=%0b d=%h exp 0/a0", bus.o_src, bus.o_data);
      end
      drive(0, '0, 0, 0, '0, 0, 1);
      tick();
   endtask

   task automatic test_random();
      bit           v[2], l[2], acc[2], e[2];
      logic [W-1:0] d[2];
      int           rem[2], waits[2];
      bit           ordy;
      for (int k = 0; k < 2; k++) begin
         v[k] = 0; l[k] = 0; d[k] = '0; rem[k] = 0; waits[k] = 0;
      end
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!v[k] && $urandom_range(0, 2) != 0) begin
               if (rem[k] == 0) rem[k] = $urandom_range(1, 4);
               v[k] = 1;
               d[k] = {$urandom, $urandom};
               l[k] = (rem[k] == 1);
            end
         end
         ordy = ($urandom_range(0, 3) != 0);
         drive(v[0], d[0], l[0], v[1], d[1], l[1], ordy);
         e[0] = m_rdy(0);
         e[1] = m_rdy(1);
         checks++;
         if (bus.req0_ready !== e[0] || bus.req1_ready !== e[1]) begin
            errors++;
            $display("FAIL rand_ready c=%0d got %0b%0b exp %0b%0b",
                     c, bus.req0_ready, bus.req1_ready, e[0], e[1]);
         end
         for (int k = 0; k < 2; k++) acc[k] = v[k] && e[k];
         for (int k = 0; k < 2; k++) begin
            if (acc[k] || !v[k]) waits[k] = 0;
            else if (acc[1-k] && l[1-k]) begin
               waits[k]++;
               checks++;
               if (waits[k] > 1) begin
                  errors++;
                  $display("FAIL rand_starve req%0d got %0d bursts exp <=1", k, waits[k]);
               end
            end
         end
         tick();
         checks++;
         if (bus.o_valid !== m_ov || bus.o_data !== m_od
             || bus.o_src !== m_os || bus.o_last !== m_ol) begin
            errors++;
            $display("FAIL rand_out c=%0d got %0b/%h/%0b/%0b exp %0b/%h/%0b/%0b",
                     c, bus.o_valid, bus.o_data, bus.o_src, bus.o_last,
                     m_ov, m_od, m_os, m_ol);
         end
         for (int k = 0; k < 2; k++) begin
            if (acc[k]) begin
               v[k] = 0;
               rem[k]--;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_contention();
      test_burst_hold();
      test_backpressure();
      test_owner_gap();
      test_reset_mid_burst();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
